// File: rtl/brp_gshare_pkg.sv
// Shared types and helpers for the gshare branch direction predictor.
// The EX stage packs a resolved branch into brp_update_t and returns it as one bundle.
package brp_gshare_pkg;

    localparam int unsigned BRP_ENTRIES = 256;
    localparam int unsigned BRP_IDX_W   = $clog2(BRP_ENTRIES);
    localparam int unsigned BRP_GHR_W   = 8;
    localparam int unsigned BRP_GHR_PW  = (BRP_GHR_W == 0) ? 1 : BRP_GHR_W;

    typedef struct packed {
        logic                  valid;
        logic [BRP_IDX_W-1:0]  idx;
        logic [BRP_GHR_PW-1:0] ghr;
        logic                  taken;
        logic                  mispredicted;
    } brp_update_t;

    // A zero-width history still needs a one-bit port.
    function automatic int unsigned brp_port_w(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

    // Weakly not-taken: 2^(w-1)-1, which is 0 for a one-bit counter.
    function automatic int unsigned brp_ctr_init(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/brp_sat_counter.sv
// Saturating up/down counter next-value logic; purely combinational so one
// instance can serve the single table entry written per cycle.
module brp_sat_counter #(
    parameter int unsigned CTR_WIDTH = 2
) (
    input  logic [CTR_WIDTH-1:0] ctr_i,
    input  logic                 en_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CTR_WIDTH-1:0] ctr_o
);

    localparam logic [CTR_WIDTH-1:0] CtrMax = '1;

    always_comb begin
        ctr_o = ctr_i;
        if (en_i) begin
            if (inc_i && !dec_i && (ctr_i != CtrMax)) begin
                ctr_o = ctr_i + CTR_WIDTH'(1);
            end else if (dec_i && !inc_i && (ctr_i != '0)) begin
                ctr_o = ctr_i - CTR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/brp_gshare.sv
// Gshare direction predictor: counter table indexed by PC XOR speculative global
// history, one-cycle lookup, EX-side counter training and history repair.
module brp_gshare
    import brp_gshare_pkg::*;
#(
    parameter int unsigned ENTRIES   = 256,
    parameter int unsigned CTR_WIDTH = 2,
    parameter int unsigned GHR_WIDTH = 8,
    parameter int unsigned IDX_LSB   = 2,
    localparam int unsigned IDX_W    = $clog2(ENTRIES),
    localparam int unsigned GHR_PW   = brp_port_w(GHR_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_req,
    input  logic [31:0]       pred_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    output logic [GHR_PW-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic [GHR_PW-1:0] upd_ghr,
    input  logic              upd_taken,
    input  logic              upd_mispredicted
);

    localparam logic [CTR_WIDTH-1:0] CtrInit = CTR_WIDTH'(brp_ctr_init(CTR_WIDTH));

    logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];
    logic [CTR_WIDTH-1:0] ctr_d [ENTRIES];
    logic [GHR_PW-1:0]    ghr_q, ghr_d;

    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0]     pred_idx_q, pred_idx_d;
    logic [GHR_PW-1:0]    pred_ghr_q, pred_ghr_d;

    logic [IDX_W-1:0]     ghr_ext;
    logic [IDX_W-1:0]     lkp_idx;
    logic [CTR_WIDTH-1:0] upd_ctr_new;
    logic [CTR_WIDTH-1:0] lkp_ctr;
    logic                 fwd_hit;
    logic                 unused_bits;

    // Only the index slice of the PC and the low history bits feed the table.
    assign unused_bits = ^{pred_pc, upd_ghr, ghr_q};

    if (GHR_WIDTH == 0) begin : g_no_ghr
        assign ghr_ext = '0;
    end else begin : g_ghr
        assign ghr_ext = IDX_W'(ghr_q);
    end

    assign lkp_idx = pred_pc[IDX_LSB +: IDX_W] ^ ghr_ext;

    brp_sat_counter #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_upd_ctr (
        .ctr_i (ctr_q[upd_idx]),
        .en_i  (upd_valid),
        .inc_i (upd_taken),
        .dec_i (!upd_taken),
        .ctr_o (upd_ctr_new)
    );

    // Write-first: a same-cycle update to the looked-up entry is forwarded.
    assign fwd_hit = upd_valid && (upd_idx == lkp_idx);
    assign lkp_ctr = fwd_hit ? upd_ctr_new : ctr_q[lkp_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_valid) begin
            ctr_d[upd_idx] = upd_ctr_new;
        end
    end

    // Repair wins over the speculative shift: fetch is being flushed anyway.
    always_comb begin
        ghr_d = ghr_q;
        if (GHR_WIDTH != 0) begin
            if (upd_valid && upd_mispredicted) begin
                ghr_d = GHR_PW'({upd_ghr, upd_taken});
            end else if (pred_req) begin
                ghr_d = GHR_PW'({ghr_q, lkp_ctr[CTR_WIDTH-1]});
            end
        end
    end

    always_comb begin
        pred_valid_d = pred_req;
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
        pred_ghr_d   = pred_ghr_q;
        if (pred_req) begin
            pred_taken_d = lkp_ctr[CTR_WIDTH-1];
            pred_idx_d   = lkp_idx;
            pred_ghr_d   = ghr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CtrInit;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
            pred_ghr_q   <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_idx   = pred_idx_q;
    assign pred_ghr   = pred_ghr_q;

endmodule

// File: tb/tb_brp_gshare.sv
// Scoreboard bench for brp_gshare: a default gshare instance and a small
// 3-bit-counter bimodal instance (no history), checked by per-DUT monitors.
module tb_brp_gshare;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_req, a_valid, a_taken, a_uv, a_ut, a_um;
    logic [31:0] a_pc;
    logic [7:0]  a_idx, a_ghr, a_uidx, a_ughr;

    logic        b_req, b_valid, b_taken, b_uv, b_ut, b_um, b_ghr, b_ughr;
    logic [31:0] b_pc;
    logic [3:0]  b_idx, b_uidx;

    brp_gshare u_dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_req         (a_req),
        .pred_pc          (a_pc),
        .pred_valid       (a_valid),
        .pred_taken       (a_taken),
        .pred_idx         (a_idx),
        .pred_ghr         (a_ghr),
        .upd_valid        (a_uv),
        .upd_idx          (a_uidx),
        .upd_ghr          (a_ughr),
        .upd_taken        (a_ut),
        .upd_mispredicted (a_um)
    );

    brp_gshare #(
        .ENTRIES   (16),
        .CTR_WIDTH (3),
        .GHR_WIDTH (0),
        .IDX_LSB   (2)
    ) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_req         (b_req),
        .pred_pc          (b_pc),
        .pred_valid       (b_valid),
        .pred_taken       (b_taken),
        .pred_idx         (b_idx),
        .pred_ghr         (b_ghr),
        .upd_valid        (b_uv),
        .upd_idx          (b_uidx),
        .upd_ghr          (b_ughr),
        .upd_taken        (b_ut),
        .upd_mispredicted (b_um)
    );

    typedef struct {
        logic       taken;
        logic [7:0] idx;
        logic [7:0] ghr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_pred{taken,idx,ghr}", {15'd0, a_taken, a_idx, a_ghr},
                      {15'd0, e.taken, e.idx, e.ghr});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                check("b_pred{taken,idx,ghr}", {26'd0, b_taken, b_idx, b_ghr},
                      {26'd0, e.taken, e.idx[3:0], e.ghr[0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_look(input logic [31:0] pc, input logic t, input logic [7:0] i,
                          input logic [7:0] g);
        a_req = 1'b1;
        a_pc  = pc;
        q_a.push_back('{taken: t, idx: i, ghr: g});
        tick();
        a_req = 1'b0;
    endtask

    task automatic a_upd(input logic [7:0] i, input logic [7:0] g, input logic t,
                         input logic m);
        a_uv   = 1'b1;
        a_uidx = i;
        a_ughr = g;
        a_ut   = t;
        a_um   = m;
        tick();
        a_uv   = 1'b0;
        a_um   = 1'b0;
    endtask

    // Lookup and update presented in the same cycle.
    task automatic a_both(input logic [31:0] pc, input logic t, input logic [7:0] i,
                          input logic [7:0] g, input logic [7:0] ui, input logic [7:0] ug,
                          input logic ut, input logic um);
        a_req  = 1'b1;
        a_pc   = pc;
        a_uv   = 1'b1;
        a_uidx = ui;
        a_ughr = ug;
        a_ut   = ut;
        a_um   = um;
        q_a.push_back('{taken: t, idx: i, ghr: g});
        tick();
        a_req  = 1'b0;
        a_uv   = 1'b0;
        a_um   = 1'b0;
    endtask

    task automatic b_look(input logic [31:0] pc, input logic t, input logic [3:0] i);
        b_req = 1'b1;
        b_pc  = pc;
        q_b.push_back('{taken: t, idx: {4'd0, i}, ghr: 8'd0});
        tick();
        b_req = 1'b0;
    endtask

    task automatic b_upd(input logic [3:0] i, input logic t);
        b_uv   = 1'b1;
        b_uidx = i;
        b_ut   = t;
        tick();
        b_uv   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_pc = '0; a_uv = 1'b0; a_uidx = '0; a_ughr = '0; a_ut = 1'b0; a_um = 1'b0;
        b_req = 1'b0; b_pc = '0; b_uv = 1'b0; b_uidx = '0; b_ughr = 1'b0; b_ut = 1'b0; b_um = 1'b0;
        repeat (2) tick();
        check("reset_a_valid", {31'd0, a_valid}, 32'd0);
        check("reset_a_taken", {31'd0, a_taken}, 32'd0);
        check("reset_a_idx", {24'd0, a_idx}, 32'd0);
        check("reset_a_ghr", {24'd0, a_ghr}, 32'd0);
        check("reset_b_valid", {31'd0, b_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // First lookup after reset; history shifts in 0 and stays 0.
        a_look(32'h100, 1'b0, 8'h40, 8'h00);

        // Five taken updates to idx 5 saturate at 3; then 3->2 (taken), 2->1 (not taken).
        repeat (5) a_upd(8'h05, 8'h00, 1'b1, 1'b0);
        a_look(32'h14, 1'b1, 8'h05, 8'h00);
        a_upd(8'h05, 8'h00, 1'b0, 1'b0);
        a_look(32'h10, 1'b1, 8'h05, 8'h01);
        a_upd(8'h05, 8'h00, 1'b0, 1'b0);
        a_look(32'h18, 1'b0, 8'h05, 8'h03);
        tick();
        check("a_hold_valid", {31'd0, a_valid}, 32'd0);
        check("a_hold_idx", {24'd0, a_idx}, 32'h05);
        check("a_hold_ghr", {24'd0, a_ghr}, 32'h03);

        // Repair to 0x0F, then to 0x79 from upd_ghr 0x3C.
        a_upd(8'h80, 8'h07, 1'b1, 1'b1);
        a_look(32'h0, 1'b0, 8'h0F, 8'h0F);
        a_upd(8'h81, 8'h3C, 1'b1, 1'b1);
        a_look(32'h0, 1'b0, 8'h79, 8'h79);

        // A correctly predicted update leaves the history alone (0xF2).
        a_upd(8'h10, 8'hAA, 1'b1, 1'b0);
        a_look(32'h0, 1'b0, 8'hF2, 8'hF2);

        // Same-cycle update to the looked-up idx: counter 1 -> 2 forwarded.
        a_both(32'h0, 1'b1, 8'hE4, 8'hE4, 8'hE4, 8'h00, 1'b1, 1'b0);
        a_look(32'hB4, 1'b1, 8'hE4, 8'hC9);

        // Mispredict repair beats the speculative shift of a same-cycle lookup.
        a_both(32'h0, 1'b0, 8'h93, 8'h93, 8'h20, 8'h55, 1'b0, 1'b1);
        a_look(32'h0, 1'b0, 8'hAA, 8'hAA);

        // Bimodal, 3-bit counters: reset value 3 means one taken update predicts taken.
        b_look(32'h0, 1'b0, 4'h0);
        b_upd(4'h2, 1'b1);
        b_look(32'h8, 1'b1, 4'h2);
        repeat (7) b_upd(4'h9, 1'b1);
        b_look(32'h24, 1'b1, 4'h9);
        b_upd(4'h9, 1'b1);
        b_look(32'h24, 1'b1, 4'h9);
        repeat (8) b_upd(4'h9, 1'b0);
        b_look(32'h24, 1'b0, 4'h9);
        repeat (3) b_upd(4'h9, 1'b1);
        b_look(32'h24, 1'b0, 4'h9);
        b_upd(4'h9, 1'b1);
        b_look(32'h24, 1'b1, 4'h9);

        // Reset while a prediction is being presented (GHR 0x54, idx 0xE4 holds 2).
        a_req = 1'b1;
        a_pc  = 32'h2C0;
        tick();
        a_req = 1'b0;
        check("pre_reset_valid", {31'd0, a_valid}, 32'd1);
        check("pre_reset_taken", {31'd0, a_taken}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_valid", {31'd0, a_valid}, 32'd0);
        check("mid_reset_taken", {31'd0, a_taken}, 32'd0);
        check("mid_reset_idx", {24'd0, a_idx}, 32'd0);
        check("mid_reset_ghr", {24'd0, a_ghr}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        a_look(32'h14, 1'b0, 8'h05, 8'h00);
        a_look(32'h390, 1'b0, 8'hE4, 8'h00);

        repeat (3) tick();
        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brp_gshare.md
Name: brp_gshare

Overview:
Parametrised direction predictor and successor to the single-counter bimodal predictor. It holds a table of ENTRIES saturating counters, each CTR_WIDTH bits wide. The table is indexed by PC bits XORed with a speculative global history register (GHR); GHR_WIDTH=0 degenerates to a per-PC bimodal table. It sits between fetch, which issues lookups, and execute, which returns branch resolution and triggers GHR repair on mispredict.

Parameters:
ENTRIES, 256, number of counters; power of two, >=2; IDX_W = $clog2(ENTRIES)
CTR_WIDTH, 2, counter bits; >=1
GHR_WIDTH, 8, history bits; 0..IDX_W
IDX_LSB, 2, lowest PC bit used for indexing

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pred_req  in  1  fetch lookup request this cycle
pred_pc  in  32  PC of the fetched branch
pred_valid  out  1  registered; high the cycle after pred_req
pred_taken  out  1  registered prediction (counter MSB)
pred_idx  out  IDX_W  table index used; carried down the pipe to EX
pred_ghr  out  max(GHR_WIDTH,1)  GHR value before this lookup's speculative shift
upd_valid  in  1  branch resolved in EX
upd_idx  in  IDX_W  pred_idx returned from EX
upd_ghr  in  max(GHR_WIDTH,1)  pred_ghr returned from EX
upd_taken  in  1  actual branch outcome
upd_mispredicted  in  1  prediction was wrong

Behaviour:
- Reset (async assert, release synchronous to clk):
  - every counter = 2^(CTR_WIDTH-1)-1 (weakly not-taken; 0 when CTR_WIDTH=1)
  - GHR = 0; pred_valid = 0, pred_taken = 0, pred_idx = 0, pred_ghr = 0
- Index: idx = pred_pc[IDX_LSB +: IDX_W] XOR zero-extended GHR.
- Lookup latency: 1 cycle.
  - On pred_req at cycle N, outputs are valid at N+1: pred_valid=1, pred_taken = MSB of counter[idx], pred_idx = idx, pred_ghr = GHR at N.
  - Without pred_req: pred_valid=0; other outputs hold their last values.
- Speculative history: on pred_req (GHR_WIDTH>0), GHR <= {GHR[GHR_WIDTH-2:0], MSB of counter[idx]} at the end of cycle N.
- Counter update on upd_valid:
  - counter[upd_idx] increments if upd_taken, otherwise decrements.
  - Saturates at 0 and at 2^CTR_WIDTH-1.
  - Visible one cycle after the upd_valid cycle.
- GHR repair on upd_valid & upd_mispredicted: GHR <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}.
- Simultaneous pred_req and upd_valid:
  - Same index: the lookup forwards the post-update counter value (write-first), so pred_taken reflects the saturated update result.
  - Mispredict repair has priority over the speculative shift. The lookup output is still produced, but its shift is discarded because fetch is flushed.
- upd_valid without mispredict never modifies the GHR.
- Reset asserted mid-operation: all state clears immediately; any in-flight prediction is dropped (pred_valid=0).
- Widths: all counter arithmetic is CTR_WIDTH bits; no overflow or wrap at either rail.

Decomposition:
- rv32i_types gains the brp_update_t struct {valid, idx, ghr, taken, mispredicted}. It is parametrised by a package-level BRP_IDX_W / BRP_GHR_W constant so the EX stage passes one bundle.
- Sub-module brp_sat_counter (CTR_WIDTH parameter; inc/dec/en inputs; saturating next-value logic) is instantiated per entry via generate, or used as a function-style combinational helper.
- The GHR and the table live in brp_gshare.

Test Plan:
- Reset then pred_req pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_idx=0x40, pred_ghr=0; the GHR is then 0 after the shift-in of 0.
- GHR_WIDTH=0, four upd_valid taken to idx 5 -> counter saturates at 3. A further taken update keeps it at 3. One not-taken update gives 2, and a lookup still predicts taken.
- CTR_WIDTH=3: seven taken updates on idx 9 -> counter 7, not 0. Eight not-taken updates -> counter 0, and a lookup predicts not-taken.
- GHR repair: GHR=0x0F, upd_valid & upd_mispredicted with upd_ghr=0x3C and upd_taken=1 -> GHR=0x79 the next cycle, and a lookup of pc 0x0 uses idx 0x79.
- Same-cycle pred_req and upd_valid to the same idx, where the counter is 1 and upd_taken=1 -> pred_taken=1 (forwarded value 2).
- Assert rst_n low in the cycle after pred_req -> pred_valid=0 immediately, all counters read weakly not-taken, and the GHR is 0.
